// File: rtl/ingre_tracker_ctrl.sv
// rtl/ingre_tracker_ctrl.sv - ingredient tracker round sequencer with count-glyph overlay renderer
module ingre_tracker_ctrl #(
  parameter int NUM_ROWS    = 3,
  parameter int START_COUNT = 2,
  parameter int Y_BASE      = 10,
  parameter int Y_STEP      = 8,
  parameter int X_DIGIT     = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        collect_valid,
  input  logic [1:0]  collect_id,
  output logic        collect_ready,
  input  logic [12:0] pix_index,
  output logic [15:0] oled_data,
  output logic [7:0]  counts,
  output logic        all_done,
  output logic        err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [15:0] COL_BG   = 16'hFDDB;
  localparam logic [15:0] COL_INK  = 16'h0000;
  localparam logic [15:0] COL_ZERO = 16'h07E0;

  localparam logic [2:0] NUM_ROWS_L = 3'(NUM_ROWS);
  localparam logic [1:0] START_L    = 2'(START_COUNT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  counts_q, counts_d;
  logic        err_q, err_d;
  logic        start_q, start_d;
  logic [1:0]  id_q, id_d;
  logic [15:0] oled_q, oled_d;

  logic        start_edge;
  logic        handshake;
  logic [7:0]  load_val;
  logic [1:0]  cur_cnt;
  logic        bad_id;

  int px, py, dx, dy;

  // 3x5 glyph lookup; caller guarantees dx in 0..2 and dy in 0..4
  function automatic logic glyph_on(input logic [1:0] cnt, input int gx, input int gy);
    logic on;
    case (cnt)
      2'd0:    on = (gx == 0) || (gx == 2) || (gy == 0) || (gy == 4);
      2'd1:    on = (gy == 0 && gx <= 1) || (gx == 1) || (gy == 4);
      default: on = (gy == 0) || (gy == 2) || (gy == 4) ||
                    (gx == 2 && gy == 1) || (gx == 0 && gy == 3);
    endcase
    return on;
  endfunction

  assign collect_ready = (state_q == ST_ACTIVE);
  assign all_done      = (state_q == ST_DONE);
  assign err           = err_q;
  assign counts        = counts_q;
  assign oled_data     = oled_q;

  // Round-start image: START_COUNT in every populated row, zero in the rest
  always_comb begin
    load_val = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      load_val[2*r +: 2] = START_L;
    end
  end

  // Round state machine, count bookkeeping and sticky error
  always_comb begin
    start_d    = start;
    start_edge = start & ~start_q;
    handshake  = collect_valid & collect_ready;
    cur_cnt    = counts_q[{id_q, 1'b0} +: 2];
    bad_id     = ({1'b0, id_q} >= NUM_ROWS_L);

    state_d  = state_q;
    counts_d = counts_q;
    err_d    = err_q;
    id_d     = id_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          counts_d = load_val;
          err_d    = 1'b0;
          state_d  = (START_L == 2'd0) ? ST_DONE : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (handshake) begin
          id_d    = collect_id;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (bad_id || cur_cnt == 2'd0) begin
          err_d = 1'b1;
        end else begin
          counts_d[{id_q, 1'b0} +: 2] = cur_cnt - 2'd1;
        end
        state_d = (counts_d == 8'd0) ? ST_DONE : ST_ACTIVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel renderer: glyph colour follows the row's registered count, IDLE is blank
  always_comb begin
    oled_d = COL_BG;
    px     = {19'd0, pix_index % 13'd96};
    py     = {19'd0, pix_index / 13'd96};
    dx     = px - X_DIGIT;
    dy     = 0;
    if (state_q != ST_IDLE) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        dy = py - (Y_BASE + r * Y_STEP);
        if (dx >= 0 && dx <= 2 && dy >= 0 && dy <= 4 &&
            glyph_on(counts_q[2*r +: 2], dx, dy)) begin
          oled_d = (counts_q[2*r +: 2] != 2'd0) ? COL_INK : COL_ZERO;
        end
      end
    end
  end

  // State registers; reset also drops any in-flight update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      counts_q <= 8'd0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      id_q     <= 2'd0;
      oled_q   <= COL_BG;
    end else begin
      state_q  <= state_d;
      counts_q <= counts_d;
      err_q    <= err_d;
      start_q  <= start_d;
      id_q     <= id_d;
      oled_q   <= oled_d;
    end
  end

endmodule

// File: tb/tb_ingre_tracker_ctrl.sv
// tb/tb_ingre_tracker_ctrl.sv - scoreboard bench for ingre_tracker_ctrl
module tb_ingre_tracker_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        collect_valid;
  logic [1:0]  collect_id;
  logic        collect_ready;
  logic [12:0] pix_index;
  logic [15:0] oled_data;
  logic [7:0]  counts;
  logic        all_done;
  logic        err;

  always #5 clk = ~clk;

  ingre_tracker_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .collect_valid (collect_valid),
    .collect_id    (collect_id),
    .collect_ready (collect_ready),
    .pix_index     (pix_index),
    .oled_data     (oled_data),
    .counts        (counts),
    .all_done      (all_done),
    .err           (err)
  );

  typedef struct {
    logic [7:0]  counts;
    logic        ready;
    logic        done;
    logic        err;
    logic [15:0] oled;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: rows of integer counts, a pending-collect slot and round flags
  int m_cnt[4];
  bit m_idle;
  bit m_done;
  bit m_err;
  bit m_start_prev;
  int m_pend;

  string g_two[5]  = '{"###", "..#", "###", "#..", "###"};
  string g_one[5]  = '{"##.", ".#.", ".#.", ".#.", "###"};
  string g_zero[5] = '{"###", "#.#", "#.#", "#.#", "###"};

  bit cur_start = 1'b0;
  bit cur_valid = 1'b0;
  logic [1:0] cur_id = 2'd0;

  task automatic check(input string nm, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
  endtask

  function automatic logic [15:0] model_pixel(input int pix);
    int x, y, dx, dy;
    string row;
    x = pix % 96;
    y = pix / 96;
    if (m_idle) return 16'hFDDB;
    for (int r = 0; r < 3; r++) begin
      dx = x - 80;
      dy = y - (10 + 8 * r);
      if (dx >= 0 && dx < 3 && dy >= 0 && dy < 5) begin
        if (m_cnt[r] == 2) row = g_two[dy];
        else if (m_cnt[r] == 1) row = g_one[dy];
        else row = g_zero[dy];
        if (row[dx] == "#") return (m_cnt[r] > 0) ? 16'h0000 : 16'h07E0;
      end
    end
    return 16'hFDDB;
  endfunction

  function automatic logic [7:0] model_counts();
    logic [7:0] c;
    c = 8'd0;
    for (int r = 0; r < 3; r++) c[2*r +: 2] = 2'(m_cnt[r]);
    return c;
  endfunction

  // One clock: drive inputs, advance the model, queue what the DUT must show after the edge
  task automatic cyc(input bit rst, input bit st, input bit v, input logic [1:0] id,
                     input int pix, output bit accepted);
    exp_t e;
    bit rdy;
    bit edge_seen;
    reset         = rst;
    start         = st;
    collect_valid = v;
    collect_id    = id;
    pix_index     = pix[12:0];
    accepted      = 1'b0;
    e.oled        = model_pixel(pix);
    if (rst) begin
      for (int r = 0; r < 4; r++) m_cnt[r] = 0;
      m_idle = 1'b1; m_done = 1'b0; m_err = 1'b0; m_start_prev = 1'b0; m_pend = -1;
      e.oled = 16'hFDDB;
    end else begin
      rdy       = !m_idle && !m_done && m_pend < 0;
      edge_seen = st && !m_start_prev;
      if (m_pend >= 0) begin
        if (m_pend >= 3 || m_cnt[m_pend] == 0) m_err = 1'b1;
        else m_cnt[m_pend] = m_cnt[m_pend] - 1;
        m_pend = -1;
        m_done = (m_cnt[0] + m_cnt[1] + m_cnt[2]) == 0;
      end else if ((m_idle || m_done) && edge_seen) begin
        for (int r = 0; r < 3; r++) m_cnt[r] = 2;
        m_err = 1'b0; m_idle = 1'b0; m_done = 1'b0;
      end else if (rdy && v) begin
        m_pend   = int'(id);
        accepted = 1'b1;
      end
      m_start_prev = st;
    end
    e.counts = model_counts();
    e.ready  = !m_idle && !m_done && m_pend < 0;
    e.done   = m_done;
    e.err    = m_err;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  function automatic int rand_pix();
    int r, x, y;
    if ($urandom_range(0, 3) != 0) begin
      r = $urandom_range(0, 3);
      y = 10 + 8 * r + $urandom_range(0, 4);
      x = $urandom_range(79, 83);
      return y * 96 + x;
    end
    return $urandom_range(0, 6143);
  endfunction

  task automatic tick(input int pix);
    bit acc;
    cyc(1'b0, cur_start, cur_valid, cur_id, pix, acc);
    if (acc) cur_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b1, cur_start, cur_valid, cur_id, rand_pix(), acc);
  endtask

  // Hold a request until the model says it was taken, bounded
  task automatic collect(input logic [1:0] id);
    int waited;
    cur_valid = 1'b1;
    cur_id    = id;
    waited    = 0;
    while (cur_valid && waited < 20) begin
      tick(rand_pix());
      waited++;
    end
    if (cur_valid) begin
      n_checks++;
      $display("FAIL collect_timeout: id %0d not accepted within %0d cycles", id, waited);
      cur_valid = 1'b0;
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set, compared against the queue head
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("counts", int'(counts), int'(mon_e.counts));
      check("collect_ready", int'(collect_ready), int'(mon_e.ready));
      check("all_done", int'(all_done), int'(mon_e.done));
      check("err", int'(err), int'(mon_e.err));
      check("oled_data", int'(oled_data), int'(mon_e.oled));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    reset = 1'b1; start = 1'b0; collect_valid = 1'b0; collect_id = 2'd0; pix_index = 13'd0;
    @(posedge clk); #1;
    do_reset(3);

    // IDLE: glyph pixels must stay background
    tick(10 * 96 + 80);
    tick(18 * 96 + 81);
    tick(26 * 96 + 82);

    // Start round, six collects with valid held, pixel probes midway
    cur_start = 1'b1; tick(10 * 96 + 80);
    tick(10 * 96 + 80);
    collect(2'd0); collect(2'd0); collect(2'd1);
    tick(18 * 96 + 80);
    tick(18 * 96 + 79);
    tick(10 * 96 + 80);
    tick(12 * 96 + 81);
    collect(2'd1); collect(2'd2); collect(2'd2);
    tick(10 * 96 + 81); tick(26 * 96 + 81);

    // Start held high in DONE: exactly one reload
    cur_start = 1'b0; tick(rand_pix());
    cur_start = 1'b1;
    for (int i = 0; i < 10; i++) tick(rand_pix());
    cur_start = 1'b0; tick(rand_pix());

    // Bad id, then collect on an emptied row
    collect(2'd3);
    collect(2'd0); collect(2'd0); collect(2'd0);
    cur_start = 1'b1; tick(rand_pix());
    cur_start = 1'b0; tick(rand_pix());
    collect(2'd1); collect(2'd1); collect(2'd2); collect(2'd2);
    tick(rand_pix());
    cur_start = 1'b1; tick(rand_pix());
    cur_start = 1'b0; tick(rand_pix());

    // Reset landing on the UPDATE cycle
    collect(2'd0);
    cyc(1'b1, cur_start, cur_valid, cur_id, 10 * 96 + 80, acc);
    tick(10 * 96 + 80);
    tick(rand_pix());

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1);
      end else begin
        if ($urandom_range(0, 11) == 0) cur_start = ~cur_start;
        if (!cur_valid && $urandom_range(0, 1) == 1) begin
          cur_valid = 1'b1;
          cur_id    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        end
        tick(rand_pix());
      end
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
